// File: rtl/axi_bw_win_mon.sv
// rtl/axi_bw_win_mon.sv - passive per-master AXI bandwidth window monitor
// Optional peak-outstanding outputs are enabled by defining BW_MON_PEAK_OSTD_EN.
module axi_bw_win_mon #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 24,
    parameter int OSTD_W = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                mon_en,
    input  logic [WIN_W-1:0]    win_cycles,
    input  logic                arvalid,
    input  logic                arready,
    input  logic                rvalid,
    input  logic                rready,
    input  logic                rlast,
    input  logic                awvalid,
    input  logic                awready,
    input  logic                wvalid,
    input  logic                wready,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    input  logic                bready,
    output logic                win_valid,
    output logic [CNT_W-1:0]    win_rd_bytes,
    output logic [CNT_W-1:0]    win_wr_bytes,
    output logic [CNT_W-1:0]    win_rd_xact,
    output logic [CNT_W-1:0]    win_wr_xact,
    output logic                win_sat,
    output logic [15:0]         win_idx,
    output logic [OSTD_W-1:0]   rd_ostd,
    output logic [OSTD_W-1:0]   wr_ostd,
    output logic                ostd_err
`ifdef BW_MON_PEAK_OSTD_EN
    ,
    output logic [OSTD_W-1:0]   win_rd_ostd_peak,
    output logic [OSTD_W-1:0]   win_wr_ostd_peak
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] RD_BEAT = CNT_W'(STRB_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic              close;
    logic [WIN_W-1:0]  timer, win_len;
    logic [CNT_W-1:0]  acc_rd_bytes, acc_wr_bytes, acc_rd_xact, acc_wr_xact;
    logic              acc_sat;
    logic [CNT_W-1:0]  wr_inc;
    logic [CNT_W:0]    nxt_rd_bytes, nxt_wr_bytes, nxt_rd_xact, nxt_wr_xact;
    logic              sat_nxt;
    logic [OSTD_W-1:0] rd_ostd_nxt, wr_ostd_nxt;
    logic              rd_err, wr_err;

    wire ar_hs = arvalid & arready;
    wire r_hs  = rvalid & rready;
    wire aw_hs = awvalid & awready;
    wire w_hs  = wvalid & wready;
    wire b_hs  = bvalid & bready;

    // Result MSB flags an overflow; the value then sticks at all-ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : sum;
    endfunction

    always_comb begin
        wr_inc = '0;
        for (int i = 0; i < STRB_W; i++)
            wr_inc = wr_inc + CNT_W'(wstrb[i]);
    end

    assign nxt_rd_bytes = sat_add(acc_rd_bytes, r_hs ? RD_BEAT : '0);
    assign nxt_wr_bytes = sat_add(acc_wr_bytes, w_hs ? wr_inc : '0);
    assign nxt_rd_xact  = sat_add(acc_rd_xact, CNT_W'(ar_hs));
    assign nxt_wr_xact  = sat_add(acc_wr_xact, CNT_W'(aw_hs));
    assign sat_nxt = acc_sat | nxt_rd_bytes[CNT_W] | nxt_wr_bytes[CNT_W]
                   | nxt_rd_xact[CNT_W] | nxt_wr_xact[CNT_W];

    always_comb begin
        state_nxt = state;
        close     = 1'b0;
        case (state)
            IDLE: if (mon_en && win_cycles != '0) state_nxt = RUN;
            RUN: begin
                if (!mon_en) begin
                    state_nxt = IDLE;
                end else if (timer == win_len - WIN_W'(1)) begin
                    close = 1'b1;
                    if (win_cycles == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            win_len      <= '0;
            timer        <= '0;
            acc_rd_bytes <= '0;
            acc_wr_bytes <= '0;
            acc_rd_xact  <= '0;
            acc_wr_xact  <= '0;
            acc_sat      <= 1'b0;
            win_valid    <= 1'b0;
            win_rd_bytes <= '0;
            win_wr_bytes <= '0;
            win_rd_xact  <= '0;
            win_wr_xact  <= '0;
            win_sat      <= 1'b0;
            win_idx      <= '0;
        end else begin
            state     <= state_nxt;
            win_valid <= close;
            if ((state == IDLE && state_nxt == RUN) || close)
                win_len <= win_cycles;
            if (state == RUN && mon_en && !close) begin
                timer        <= timer + WIN_W'(1);
                acc_rd_bytes <= nxt_rd_bytes[CNT_W-1:0];
                acc_wr_bytes <= nxt_wr_bytes[CNT_W-1:0];
                acc_rd_xact  <= nxt_rd_xact[CNT_W-1:0];
                acc_wr_xact  <= nxt_wr_xact[CNT_W-1:0];
                acc_sat      <= sat_nxt;
            end else begin
                // Idle, discarded partial window, or boundary: restart with no dead cycle.
                timer        <= '0;
                acc_rd_bytes <= '0;
                acc_wr_bytes <= '0;
                acc_rd_xact  <= '0;
                acc_wr_xact  <= '0;
                acc_sat      <= 1'b0;
            end
            if (close) begin
                win_rd_bytes <= nxt_rd_bytes[CNT_W-1:0];
                win_wr_bytes <= nxt_wr_bytes[CNT_W-1:0];
                win_rd_xact  <= nxt_rd_xact[CNT_W-1:0];
                win_wr_xact  <= nxt_wr_xact[CNT_W-1:0];
                win_sat      <= sat_nxt;
                win_idx      <= win_idx + 16'd1;
            end
        end
    end

    always_comb begin
        rd_ostd_nxt = rd_ostd;
        rd_err      = 1'b0;
        if (ar_hs && !(r_hs && rlast)) begin
            if (&rd_ostd) rd_err = 1'b1;
            else          rd_ostd_nxt = rd_ostd + OSTD_W'(1);
        end else if (!ar_hs && r_hs && rlast) begin
            if (rd_ostd == '0) rd_err = 1'b1;
            else               rd_ostd_nxt = rd_ostd - OSTD_W'(1);
        end
        wr_ostd_nxt = wr_ostd;
        wr_err      = 1'b0;
        if (aw_hs && !b_hs) begin
            if (&wr_ostd) wr_err = 1'b1;
            else          wr_ostd_nxt = wr_ostd + OSTD_W'(1);
        end else if (!aw_hs && b_hs) begin
            if (wr_ostd == '0) wr_err = 1'b1;
            else               wr_ostd_nxt = wr_ostd - OSTD_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ostd  <= '0;
            wr_ostd  <= '0;
            ostd_err <= 1'b0;
        end else begin
            rd_ostd  <= rd_ostd_nxt;
            wr_ostd  <= wr_ostd_nxt;
            ostd_err <= ostd_err | rd_err | wr_err;
        end
    end

`ifdef BW_MON_PEAK_OSTD_EN
    logic [OSTD_W-1:0] rd_peak, wr_peak;

    // Trackers hold the max of the live value from window start through the current cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_peak          <= '0;
            wr_peak          <= '0;
            win_rd_ostd_peak <= '0;
            win_wr_ostd_peak <= '0;
        end else begin
            if (state != RUN || !mon_en || close) begin
                rd_peak <= rd_ostd_nxt;
                wr_peak <= wr_ostd_nxt;
            end else begin
                if (rd_ostd_nxt > rd_peak) rd_peak <= rd_ostd_nxt;
                if (wr_ostd_nxt > wr_peak) wr_peak <= wr_ostd_nxt;
            end
            if (close) begin
                win_rd_ostd_peak <= rd_peak;
                win_wr_ostd_peak <= wr_peak;
            end
        end
    end
`endif

endmodule

// File: doc/axi_bw_win_mon.md
Name: axi_bw_win_mon

Overview:
- Passive per-master AXI bandwidth monitor; one instance is bound onto each monitored master port by the per-master bind files.
- Feeds the bandwidth-monitor top level, which collects one record per window from every master.
- Counts read/write address handshakes, data bytes and outstanding transactions over a programmable window of clock cycles.
- At each window close it latches the totals into registered outputs and pulses a record-valid strobe.

Parameters:
- DATA_W, 128, AXI data bus width in bits; a multiple of 8.
- CNT_W, 32, width of the byte and transaction accumulators.
- WIN_W, 24, width of the window-length input and timer.
- OSTD_W, 8, width of the outstanding-transaction counters.

Ports:
- aclk  in  1  monitor clock, same as the monitored AXI port.
- aresetn  in  1  asynchronous active-low reset.
- mon_en  in  1  level enable; windows run only while high.
- win_cycles  in  WIN_W  window length in cycles; sampled on entry to RUN.
- arvalid, arready  in  1 each  AR channel handshake.
- rvalid, rready, rlast  in  1 each  R channel.
- awvalid, awready  in  1 each  AW channel handshake.
- wvalid, wready  in  1 each  W channel.
- wstrb  in  DATA_W/8  write strobes.
- bvalid, bready  in  1 each  B channel.
- win_valid  out  1  one-cycle pulse: window record is updated.
- win_rd_bytes  out  CNT_W  read bytes in the last closed window.
- win_wr_bytes  out  CNT_W  write bytes in the last closed window.
- win_rd_xact  out  CNT_W  AR handshakes in the last closed window.
- win_wr_xact  out  CNT_W  AW handshakes in the last closed window.
- win_sat  out  1  an accumulator saturated during the last closed window.
- win_idx  out  16  index of the last closed window; wraps at 0xFFFF back to 0.
- rd_ostd  out  OSTD_W  live outstanding reads.
- wr_ostd  out  OSTD_W  live outstanding writes.
- ostd_err  out  1  sticky: an outstanding counter would have underflowed or overflowed.

Behaviour:
- Reset: all outputs, accumulators, the timer, win_idx and the FSM (IDLE) are cleared to 0.
- Handshake definition: a handshake is valid & ready in the same cycle.
- Read byte count: each R handshake adds DATA_W/8.
- Write byte count: each W handshake adds popcount(wstrb).
- Transaction counts: one per AR handshake and one per AW handshake.
- FSM state IDLE: accumulators and timer are held at 0. Go to RUN when mon_en==1 and win_cycles!=0; latch win_cycles internally at that point.
- FSM state RUN: timer increments each cycle; every handshake in that cycle is accumulated.
- Window close: when timer==latched_len-1 that cycle is the last of the window, and its events count toward the closing window.
- Record update: on the next cycle win_valid=1 for one cycle, the record outputs show the closed totals, and win_idx increments.
- Accumulators and timer restart from 0 at the window boundary with no dead cycle, so beats in the first cycle of the new window are counted.
- Record hold: record outputs hold until the next close.
- Re-latching window length: win_cycles is re-latched at every window close; changes mid-window take effect from the next window.
- mon_en falling in RUN: go to IDLE next cycle; the partial window is discarded (no win_valid); records and win_idx are held.
- win_cycles==0 in IDLE: stay in IDLE.
- Window length 1: every cycle closes a window, so win_valid is continuously high.
- Saturation: accumulators stick at all-ones; any saturation sets a window-local flag, which is reported as win_sat and cleared for the next window.
- Outstanding tracking runs independently of mon_en (always, except in reset).
- rd_ostd: +1 on AR handshake, −1 on R handshake with rlast; both in the same cycle leaves it unchanged.
- wr_ostd: +1 on AW handshake, −1 on B handshake; simultaneous events cancel.
- Outstanding limits: a decrement at 0 or an increment at all-ones is blocked (value clamped) and sets ostd_err. ostd_err clears only on reset.
- Reset mid-window: everything returns to reset values immediately (asynchronous); no win_valid is produced.

Optional Feature:
- Macro BW_MON_PEAK_OSTD_EN.
- When defined, two extra outputs win_rd_ostd_peak and win_wr_ostd_peak (OSTD_W each) are added. Each holds the maximum rd_ostd/wr_ostd value seen during the closed window, including the value at window start. They update with win_valid, reset to 0, and the peak trackers restart at the window boundary from the current live value.
- When undefined, those ports and logic do not exist; all other behaviour is identical.

Test Plan:
- DATA_W=128, win_cycles=100, 10 R beats at full rate plus 1 AR -> one win_valid at cycle 101 after RUN entry; win_rd_bytes=160, win_rd_xact=1, win_idx=1.
- 4 W beats with wstrb=0xFFFF, 0x00FF, 0x000F, 0x0000 -> win_wr_bytes=28.
- win_cycles=4, R beat on window-close cycle and on the next cycle -> first record rd_bytes=16, second record rd_bytes=16; no beat lost.
- AR and R-with-rlast handshake in the same cycle at rd_ostd=3 -> rd_ostd stays 3; B handshake at wr_ostd=0 -> wr_ostd=0, ostd_err=1.
- mon_en drops at cycle 50 of a 100-cycle window -> no win_valid, records unchanged; re-enable -> fresh window with zeroed counts.
- CNT_W=8, win_cycles=40, continuous R beats (16 B each) -> win_rd_bytes=0xFF, win_sat=1; the next window with zero traffic reports win_sat=0.
